// File: rtl/quadrature_pkg.sv
// Shared constants for the quadrature rate blocks: FSM encodings and default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package quadrature_pkg;

   // Default widths of the position count, velocity word and window length
   localparam int COUNT_W       = 32;
   localparam int VEL_W         = 16;
   localparam int WIN_W         = 24;
   localparam int STALL_WINDOWS = 4;

   // Measurement FSM encodings: IDLE, ARM, RUN
   typedef logic [1:0] qvel_state_t;
   localparam qvel_state_t ST_IDLE = 2'd0;
   localparam qvel_state_t ST_ARM  = 2'd1;
   localparam qvel_state_t ST_RUN  = 2'd2;

endpackage : quadrature_pkg

// File: rtl/qvel_saturate.sv
// Clips a signed IN_W two's-complement value to OUT_W bits and flags when clipping happened.
// Latency: purely combinational.
// Backpressure: none; output follows input every cycle.
module qvel_saturate #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 16
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout,
   output logic             sat
);

   // The value fits when every bit from the output sign position upward agrees
   logic [IN_W-OUT_W:0] upper;
   logic                fits;

   assign upper = din[IN_W-1:OUT_W-1];
   assign fits  = (&upper) | ~(|upper);

   // Pass the value through when it fits, otherwise clamp towards its sign
   always_comb begin
      dout = din[OUT_W-1:0];
      sat  = 1'b0;
      if (!fits) begin
         sat = 1'b1;
         if (din[IN_W-1]) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
         end else begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
         end
      end
   end

endmodule : qvel_saturate

// File: rtl/quadrature_velocity.sv
// Samples the decoder position once per window and reports the saturated signed delta as velocity.
// Latency: vel/vel_valid one cycle after each window expiry; first result W+2 edges after enable rises.
// Backpressure: none; vel_valid is a one-cycle strobe. Optional stall detect under QVEL_STALL_DETECT_EN.
module quadrature_velocity #(
   parameter int COUNT_W       = quadrature_pkg::COUNT_W,
   parameter int VEL_W         = quadrature_pkg::VEL_W,
   parameter int WIN_W         = quadrature_pkg::WIN_W,
   parameter int STALL_WINDOWS = quadrature_pkg::STALL_WINDOWS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [COUNT_W-1:0] count,
   input  logic               enable,
   input  logic [WIN_W-1:0]   window,
   output logic [VEL_W-1:0]   vel,
   output logic               vel_valid,
   output logic               sat,
   output logic               stalled
);

   import quadrature_pkg::*;

   localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

   qvel_state_t        state_q,     state_d;
   logic [WIN_W-1:0]   timer_q,     timer_d;
   logic [WIN_W-1:0]   win_len_q,   win_len_d;
   logic [COUNT_W-1:0] baseline_q,  baseline_d;
   logic [VEL_W-1:0]   vel_q,       vel_d;
   logic               vel_valid_q, vel_valid_d;
   logic               sat_q,       sat_d;

   // Modular subtraction: counter wrap in either direction still gives the small true delta
   logic [COUNT_W-1:0] delta;
   logic [VEL_W-1:0]   clip_val;
   logic               clip_sat;
   logic               expire;

   assign delta  = count - baseline_q;
   assign expire = enable && (state_q == ST_RUN) && (timer_q == '0);

   qvel_saturate #(
      .IN_W  (COUNT_W),
      .OUT_W (VEL_W)
   ) u_sat (
      .din  (delta),
      .dout (clip_val),
      .sat  (clip_sat)
   );

   // Window FSM: arm captures baseline and length, run counts down and reports at expiry
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      win_len_d   = win_len_q;
      baseline_d  = baseline_q;
      vel_d       = vel_q;
      sat_d       = sat_q;
      vel_valid_d = 1'b0;

      if (!enable) begin
         // Abort: the window in flight is dropped, outputs keep their last result
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ARM;
            end
            ST_ARM: begin
               baseline_d = count;
               win_len_d  = (window == '0) ? WIN_ONE : window;
               timer_d    = win_len_d - WIN_ONE;
               state_d    = ST_RUN;
            end
            ST_RUN: begin
               if (timer_q == '0) begin
                  // The count seen here closes this window and opens the next one
                  baseline_d  = count;
                  timer_d     = win_len_q - WIN_ONE;
                  vel_d       = clip_val;
                  sat_d       = clip_sat;
                  vel_valid_d = 1'b1;
               end else begin
                  timer_d = timer_q - WIN_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and result registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         win_len_q   <= WIN_ONE;
         baseline_q  <= '0;
         vel_q       <= '0;
         vel_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         win_len_q   <= win_len_d;
         baseline_q  <= baseline_d;
         vel_q       <= vel_d;
         vel_valid_q <= vel_valid_d;
         sat_q       <= sat_d;
      end
   end

   assign vel       = vel_q;
   assign vel_valid = vel_valid_q;
   assign sat       = sat_q;

`ifdef QVEL_STALL_DETECT_EN
   localparam int ZR_W = $clog2(STALL_WINDOWS + 1);
   localparam logic [ZR_W-1:0] ZR_MAX = ZR_W'(STALL_WINDOWS);

   logic [ZR_W-1:0] zrun_q,    zrun_d;
   logic            stalled_q, stalled_d;

   // Count consecutive zero-delta windows; stalled updates together with vel_valid
   always_comb begin
      zrun_d    = zrun_q;
      stalled_d = stalled_q;
      if (enable && (state_q == ST_ARM)) begin
         zrun_d = '0;
      end else if (expire) begin
         if (delta == '0) begin
            zrun_d = (zrun_q == ZR_MAX) ? zrun_q : zrun_q + 1'b1;
         end else begin
            zrun_d = '0;
         end
         stalled_d = (zrun_d == ZR_MAX);
      end
   end

   // Zero-run counter and stall flag registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         zrun_q    <= '0;
         stalled_q <= 1'b0;
      end else begin
         zrun_q    <= zrun_d;
         stalled_q <= stalled_d;
      end
   end

   assign stalled = stalled_q;
`else
   assign stalled = 1'b0;
`endif

endmodule : quadrature_velocity

// File: tb/tb_quadrature_velocity.sv
// Self-checking bench for quadrature_velocity: table of single-window vectors plus multi-cycle sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_quadrature_velocity;

   logic        clk;
   logic        reset;
   logic [31:0] count;
   logic        enable;
   logic [23:0] window;
   logic [15:0] vel;
   logic        vel_valid;
   logic        sat;
   logic        stalled;

   int checks;
   int errors;

   quadrature_velocity dut (
      .clk       (clk),
      .reset     (reset),
      .count     (count),
      .enable    (enable),
      .window    (window),
      .vel       (vel),
      .vel_valid (vel_valid),
      .sat       (sat),
      .stalled   (stalled)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] win;
      logic [31:0] c0;
      logic [31:0] c1;
      logic [15:0] exp_vel;
      logic        exp_sat;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Advance one clock edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Return to IDLE, then arm with baseline c0; returns just after the arm edge E0
   task automatic arm(input logic [31:0] c0, input logic [23:0] win);
      enable = 1'b0;
      count  = c0;
      window = win;
      step();
      enable = 1'b1;
      step();
      step();
   endtask

   initial begin
      int weff;
      int early;
      logic [31:0] c;
      int deltas [5];

      checks = 0;
      errors = 0;
      reset  = 1'b0;
      enable = 1'b0;
      count  = '0;
      window = 24'd8;

      vecs[0]  = '{24'd8, 32'd100,        32'd103,        16'h0003, 1'b0};
      vecs[1]  = '{24'd8, 32'hFFFF_FFFE,  32'h0000_0001,  16'h0003, 1'b0};
      vecs[2]  = '{24'd8, 32'd2,          32'hFFFF_FFFD,  16'hFFFB, 1'b0};
      vecs[3]  = '{24'd4, 32'd0,          32'd40000,      16'h7FFF, 1'b1};
      vecs[4]  = '{24'd4, 32'd40000,      32'd0,          16'h8000, 1'b1};
      vecs[5]  = '{24'd2, 32'd0,          32'd32767,      16'h7FFF, 1'b0};
      vecs[6]  = '{24'd2, 32'd0,          32'd32768,      16'h7FFF, 1'b1};
      vecs[7]  = '{24'd2, 32'd32768,      32'd0,          16'h8000, 1'b0};
      vecs[8]  = '{24'd2, 32'd32769,      32'd0,          16'h8000, 1'b1};
      vecs[9]  = '{24'd0, 32'd50,         32'd49,         16'hFFFF, 1'b0};
      vecs[10] = '{24'd1, 32'd7,          32'd7,          16'h0000, 1'b0};
      vecs[11] = '{24'd3, 32'd0,          32'hFFFF_8001,  16'h8001, 1'b0};

      // Reset state
      #1;
      check("rst_vel",       {16'h0, vel}, 32'h0);
      check("rst_vel_valid", {31'h0, vel_valid}, 32'h0);
      check("rst_sat",       {31'h0, sat}, 32'h0);
      check("rst_stalled",   {31'h0, stalled}, 32'h0);
      step();
      step();
      #2 reset = 1'b1;
      step();

      // Table: one window per vector, single pulse exactly W edges after arm
      for (int i = 0; i < 12; i++) begin
         weff = (vecs[i].win == 0) ? 1 : int'(vecs[i].win);
         arm(vecs[i].c0, vecs[i].win);
         count = vecs[i].c1;
         early = 0;
         for (int k = 1; k < weff; k++) begin
            step();
            if (vel_valid) early++;
         end
         check($sformatf("vec%0d_early_valid", i), early, 0);
         step();
         check($sformatf("vec%0d_valid", i), {31'h0, vel_valid}, 32'h1);
         check($sformatf("vec%0d_vel", i),   {16'h0, vel}, {16'h0, vecs[i].exp_vel});
         check($sformatf("vec%0d_sat", i),   {31'h0, sat}, {31'h0, vecs[i].exp_sat});
         step();
         if (weff > 1)
            check($sformatf("vec%0d_pulse_end", i), {31'h0, vel_valid}, 32'h0);
      end

      // Periodic windows, W=8, count rising 1 per cycle: 8 per window, nothing lost
      arm(32'd1000, 24'd8);
      count = 32'd1001;
      for (int k = 1; k <= 32; k++) begin
         step();
         check($sformatf("per_valid_k%0d", k), {31'h0, vel_valid}, {31'h0, (k % 8) == 0});
         if ((k % 8) == 0)
            check($sformatf("per_vel_k%0d", k), {16'h0, vel}, 32'd8);
         count = 32'd1000 + k + 1;
      end

      // Abort mid-window and re-arm: aborted window never reported, outputs held
      arm(32'd500, 24'd16);
      for (int k = 1; k <= 10; k++) begin
         count = 32'd500 + 3 * k;
         step();
      end
      enable = 1'b0;
      early  = 0;
      for (int k = 0; k < 10; k++) begin
         count = count + 32'd7;
         step();
         if (vel_valid) early++;
      end
      check("abort_no_valid", early, 0);
      check("abort_vel_held", {16'h0, vel}, 32'd8);
      check("abort_sat_held", {31'h0, sat}, 32'h0);
      count  = 32'd9000;
      enable = 1'b1;
      step();
      step();
      count = 32'd9005;
      early = 0;
      for (int k = 1; k < 16; k++) begin
         step();
         if (vel_valid) early++;
      end
      check("rearm_early_valid", early, 0);
      step();
      check("rearm_valid", {31'h0, vel_valid}, 32'h1);
      check("rearm_vel",   {16'h0, vel}, 32'd5);

      // window=0 acts as W=1: a result every cycle equal to the per-cycle change
      deltas = '{1, -2, 0, 7, -100};
      arm(32'd200, 24'd0);
      c = 32'd200;
      for (int i = 0; i < 5; i++) begin
         c     = c + 32'(deltas[i]);
         count = c;
         step();
         check($sformatf("w0_valid_%0d", i), {31'h0, vel_valid}, 32'h1);
         check($sformatf("w0_vel_%0d", i),   {16'h0, vel}, {16'h0, 16'(deltas[i])});
      end
`ifndef QVEL_STALL_DETECT_EN
      check("stalled_tied_low", {31'h0, stalled}, 32'h0);
`endif

      // window changes while running are ignored until re-arm
      arm(32'd0, 24'd4);
      window = 24'd10;
      for (int k = 1; k <= 8; k++) begin
         step();
         check($sformatf("winchg_valid_k%0d", k), {31'h0, vel_valid}, {31'h0, (k % 4) == 0});
      end

      // Asynchronous reset mid-window clears outputs before the next edge
      arm(32'd0, 24'd4);
      count = 32'd7;
      for (int k = 0; k < 4; k++) step();
      check("pre_rst_vel", {16'h0, vel}, 32'd7);
      step();
      #2 reset = 1'b0;
      #1;
      check("arst_vel",       {16'h0, vel}, 32'h0);
      check("arst_vel_valid", {31'h0, vel_valid}, 32'h0);
      check("arst_sat",       {31'h0, sat}, 32'h0);
      #2 reset = 1'b1;
      step();
      step();
      count = 32'd10;
      early = 0;
      for (int k = 1; k < 4; k++) begin
         step();
         if (vel_valid) early++;
      end
      check("post_rst_early_valid", early, 0);
      step();
      check("post_rst_valid", {31'h0, vel_valid}, 32'h1);
      check("post_rst_vel",   {16'h0, vel}, 32'd3);

`ifdef QVEL_STALL_DETECT_EN
      // Stall detect: 4 zero windows raise stalled, one moving window drops it
      arm(32'd50, 24'd2);
      for (int w = 1; w <= 4; w++) begin
         step();
         step();
         check($sformatf("stall_valid_w%0d", w), {31'h0, vel_valid}, 32'h1);
         check($sformatf("stall_flag_w%0d", w),  {31'h0, stalled}, {31'h0, w == 4});
      end
      count = 32'd51;
      step();
      step();
      check("unstall_vel",  {16'h0, vel}, 32'd1);
      check("unstall_flag", {31'h0, stalled}, 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_quadrature_velocity
